cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Common Data Bus transmitter. It collects completed results (ROB entry tag plus value) from several functional units. Each unit feeds a small per-source FIFO. One result per cycle is selected and broadcast as a registered, single-cycle CDB write. The broadcast drives the ROB's cdb_write/cdb_in_entry/cdb_in_value inputs and the reservation-station snoop ports.

Parameters:
NUM_SRC, 4, number of functional-unit result sources (2..8)
DATA_W, 32, result value width; equals `Data_Width
ENTRY_W, 3, ROB tag width; equals `ROB_Entry_Width
FIFO_DEPTH, 2, per-source buffer depth; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  bit i: source i presents a result
src_ready  out  NUM_SRC  bit i: source i FIFO can accept this cycle
src_entry  in  NUM_SRC*ENTRY_W  packed ROB tags; source i at [i*ENTRY_W +: ENTRY_W]
src_value  in  NUM_SRC*DATA_W  packed values; source i at [i*DATA_W +: DATA_W]
cdb_write  out  1  broadcast valid, one cycle per result
cdb_entry  out  ENTRY_W  broadcast ROB tag
cdb_value  out  DATA_W  broadcast value
cdb_src  out  clog2(NUM_SRC)  index of the source that produced the current broadcast

Behaviour:
- Reset, synchronous, active-high, clock clk.
  - All FIFOs are emptied; rr_ptr=0.
  - cdb_write=0, cdb_entry=0, cdb_value=0, cdb_src=0.
  - src_ready is forced to 0 while rst=1.
  - Reset asserted mid-operation discards all buffered results; nothing is broadcast on the following cycle.
- Handshake:
  - src_ready[i] = !rst && (count_i < FIFO_DEPTH).
  - It is a function of registered count only and does not depend on src_valid or on the same-cycle pop.
  - A push to FIFO i happens at the edge when src_valid[i] && src_ready[i].
  - A source must hold valid/entry/value stable until accepted.
- Arbitration, combinational on FIFO heads each cycle:
  - Candidates are the non-empty FIFOs.
  - The winner is selected per the Optional Feature rule.
  - The winner's head is popped at the edge.
  - That same edge registers cdb_write=1, cdb_entry=head tag, cdb_value=head value, cdb_src=winner index.
  - With no candidate, cdb_write<=0. cdb_entry, cdb_value and cdb_src hold their previous values.
- Latency: a result accepted at edge k into an empty FIFO with no competition is on the CDB after edge k+1, i.e. visible for the cycle between edges k+1 and k+2. There is no input-to-CDB bypass.
- Throughput: exactly one broadcast per cycle maximum. Each accepted result is broadcast exactly once. Per-source FIFO order is preserved.
- Simultaneous push and pop on the same FIFO:
  - Permitted whenever count < FIFO_DEPTH; count is unchanged.
  - On a full FIFO no push occurs, because ready=0. A pop frees a slot and ready rises on the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH, so the count register is clog2(FIFO_DEPTH)+1 bits wide.
- Tags are not checked. Duplicate tags from different sources are both broadcast, in arbitration order.

Optional Feature:
Macro CDB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at rr_ptr and proceeds upward, wrapping at NUM_SRC.
  - After a grant to index g, rr_ptr <= (g+1) mod NUM_SRC.
  - rr_ptr holds when there is no grant.
- Undefined: fixed priority, where the lowest-index non-empty FIFO wins. rr_ptr is not implemented.
- All ports are identical in both builds.

Decomposition:
- Shared defines file:
  - `Data_Width and `ROB_Entry_Width, already present, are the defaults for DATA_W/ENTRY_W.
  - Add `CDB_Src_Num (default 4).
- One sub-module: cdb_src_fifo.
  - Parameterised on DATA_W+ENTRY_W width and FIFO_DEPTH.
  - Ports: push, pop, din, dout, empty, full.
  - Instantiated NUM_SRC times via generate.
- Arbiter and CDB output register live in cdb_arbiter.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then 0 with all src_valid=0 -> cdb_write=0 every cycle; src_ready=4'b0000 during reset and 4'b1111 after.
2. Single result: src 2 presents entry=5, value=0xDEADBEEF, accepted at edge k -> after edge k+1 cdb_write=1, cdb_entry=5, cdb_value=0xDEADBEEF, cdb_src=2 for one cycle, then cdb_write=0.
3. Contention with CDB_RR_EN: all 4 sources present one result in the same cycle (entries 0,1,2,3) -> four consecutive broadcasts with cdb_src 0,1,2,3. A repeat burst while rr_ptr=1 yields order 1,2,3,0. Without the macro, order is always 0,1,2,3.
4. Backpressure: source 0 drives valid continuously with entries 1,2,3,4 while source 1 is also always non-empty under fixed priority -> source 0 drains every cycle and source 1 starves. Under round-robin: src_ready[0] drops to 0 once count=2, rises after a pop, and entries 1,2,3,4 appear in order with none lost or duplicated.
5. Reset mid-burst: two results buffered in FIFO 3, rst asserted for 1 cycle -> no broadcast of either result; cdb_write=0 after reset; FIFO 3 is empty, shown by a fresh push broadcast after 1 cycle.
6. Push+pop on a FIFO with count=1: source 1 pushes entry 6 in the same cycle its head (entry 7) wins -> entry 7 broadcast, count stays 1, entry 6 broadcast the next cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : cdb_arbiter_pkg
// Brief    : Shared widths and helpers for the Common Data Bus transmitter.
//            Optional macro CDB_RR_EN selects round-robin arbitration.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef ROB_Entry_Width
`define ROB_Entry_Width 3
`endif
`ifndef CDB_Src_Num
`define CDB_Src_Num 4
`endif

package cdb_arbiter_pkg;

    localparam int CDB_DATA_W_DEF  = `Data_Width;
    localparam int CDB_ENTRY_W_DEF = `ROB_Entry_Width;
    localparam int CDB_NUM_SRC_DEF = `CDB_Src_Num;
    localparam int CDB_FIFO_DEF    = 2;

    // Next round-robin start point after a grant to idx.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_src_fifo.sv
//------------------------------------------------------------------------------
// Module   : cdb_src_fifo
// Brief    : Per-source result buffer (tag + value), power-of-two depth.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdb_src_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cdb_arbiter
// Brief    : CDB transmitter: buffers FU results and broadcasts one per cycle.
//            Define CDB_RR_EN for round-robin, otherwise fixed priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = CDB_NUM_SRC_DEF,
    parameter int DATA_W     = CDB_DATA_W_DEF,
    parameter int ENTRY_W    = CDB_ENTRY_W_DEF,
    parameter int FIFO_DEPTH = CDB_FIFO_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*ENTRY_W-1:0]   src_entry,
    input  logic [NUM_SRC*DATA_W-1:0]    src_value,
    output logic                         cdb_write,
    output logic [ENTRY_W-1:0]           cdb_entry,
    output logic [DATA_W-1:0]            cdb_value,
    output logic [$clog2(NUM_SRC)-1:0]   cdb_src
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int W  = DATA_W + ENTRY_W;

    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [W-1:0]       w_head [NUM_SRC];
    logic [W-1:0]       w_head_sel;
    logic               w_grant_vld;
    logic [SW-1:0]      w_grant_idx;

    logic               cdb_write_q;
    logic [ENTRY_W-1:0] cdb_entry_q;
    logic [DATA_W-1:0]  cdb_value_q;
    logic [SW-1:0]      cdb_src_q;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign src_ready[i] = !rst && !w_full[i];
            assign w_push[i]    = src_valid[i] && src_ready[i];
            assign w_pop[i]     = w_grant_vld && (w_grant_idx == SW'(i));

            cdb_src_fifo #(
                .WIDTH (W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push[i]),
                .pop   (w_pop[i]),
                .din   ({src_entry[i*ENTRY_W +: ENTRY_W], src_value[i*DATA_W +: DATA_W]}),
                .dout  (w_head[i]),
                .empty (w_empty[i]),
                .full  (w_full[i])
            );
        end
    endgenerate

`ifdef CDB_RR_EN
    logic [SW-1:0] rr_ptr_q;

    // Scan downward in distance from rr_ptr so the closest candidate is the last to assign.
    always_comb begin
        logic [SW-1:0] idx_sel;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx_sel     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx_sel = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (!w_empty[idx_sel]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (w_grant_vld) begin
            rr_ptr_q <= SW'(rr_next(int'(w_grant_idx), NUM_SRC));
        end
    end
`else
    always_comb begin
        logic [SW-1:0] idx_sel;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx_sel     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx_sel = SW'(k);
            if (!w_empty[idx_sel]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx_sel;
            end
        end
    end
`endif

    assign w_head_sel = w_head[w_grant_idx];

    // Tag/value/source hold their last broadcast when the bus is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_write_q <= 1'b0;
            cdb_entry_q <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            cdb_write_q <= w_grant_vld;
            if (w_grant_vld) begin
                cdb_entry_q <= w_head_sel[W-1:DATA_W];
                cdb_value_q <= w_head_sel[DATA_W-1:0];
                cdb_src_q   <= w_grant_idx;
            end
        end
    end

    assign cdb_write = cdb_write_q;
    assign cdb_entry = cdb_entry_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_cdb_arbiter
// Brief    : Randomized self-checking bench for cdb_arbiter against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;

    localparam int NS    = 4;
    localparam int DW    = 32;
    localparam int EW    = 3;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*EW-1:0]  src_entry;
    logic [NS*DW-1:0]  src_value;
    logic              cdb_write;
    logic [EW-1:0]     cdb_entry;
    logic [DW-1:0]     cdb_value;
    logic [1:0]        cdb_src;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_SRC    (NS),
        .DATA_W     (DW),
        .ENTRY_W    (EW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_entry (src_entry),
        .src_value (src_value),
        .cdb_write (cdb_write),
        .cdb_entry (cdb_entry),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: one queue of {tag,value} per source plus the expected bus state.
    logic [EW+DW-1:0] mq [NS][$];
    int               rr;
    logic             exp_write;
    logic [EW-1:0]    exp_entry;
    logic [DW-1:0]    exp_value;
    logic [1:0]       exp_src;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [NS-1:0]    rdy;
        logic [NS-1:0]    acc;
        logic [EW+DW-1:0] w;
        int               win;
        int               s;
        #1;
        for (int i = 0; i < NS; i++) rdy[i] = !rst && (mq[i].size() < DEPTH);
        check_val("src_ready", 64'(src_ready), 64'(rdy));
        acc = src_valid & rdy;
        win = -1;
        for (int k = 0; k < NS; k++) begin
`ifdef CDB_RR_EN
            s = (rr + k) % NS;
`else
            s = k;
`endif
            if (win < 0 && mq[s].size() > 0) win = s;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            rr        = 0;
            exp_write = 1'b0;
            exp_entry = '0;
            exp_value = '0;
            exp_src   = '0;
        end else begin
            if (win >= 0) begin
                w         = mq[win].pop_front();
                exp_write = 1'b1;
                exp_entry = w[EW+DW-1:DW];
                exp_value = w[DW-1:0];
                exp_src   = 2'(win);
                rr        = (win + 1) % NS;
            end else begin
                exp_write = 1'b0;
            end
            for (int i = 0; i < NS; i++)
                if (acc[i]) mq[i].push_back({src_entry[i*EW +: EW], src_value[i*DW +: DW]});
        end
        check_val("cdb_write", 64'(cdb_write), 64'(exp_write));
        check_val("cdb_entry", 64'(cdb_entry), 64'(exp_entry));
        check_val("cdb_value", 64'(cdb_value), 64'(exp_value));
        check_val("cdb_src",   64'(cdb_src),   64'(exp_src));
        for (int i = 0; i < NS; i++) if (acc[i]) src_valid[i] = 1'b0;
    endtask

    task automatic present(input int i, input logic [EW-1:0] e, input logic [DW-1:0] v);
        src_valid[i]          = 1'b1;
        src_entry[i*EW +: EW] = e;
        src_value[i*DW +: DW] = v;
    endtask

    task automatic offer(input int pct);
        for (int i = 0; i < NS; i++)
            if (!src_valid[i] && $urandom_range(99) < pct)
                present(i, EW'($urandom), $urandom);
    endtask

    initial begin
        int left;
        rst       = 1'b1;
        src_valid = '0;
        src_entry = '0;
        src_value = '0;
        rr        = 0;
        exp_write = 1'b0;
        exp_entry = '0;
        exp_value = '0;
        exp_src   = '0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();

        // Single result from source 2
        present(2, 3'd5, 32'hDEADBEEF);
        repeat (3) step();

        // All four sources at once, then a second burst
        for (int i = 0; i < NS; i++) present(i, EW'(i), 32'h1000 + i);
        repeat (6) step();
        for (int i = 0; i < NS; i++) present(i, EW'(i), 32'h2000 + i);
        repeat (6) step();

        // Push into a FIFO whose head wins in the same cycle
        present(1, 3'd7, 32'h7777);
        step();
        present(1, 3'd6, 32'h6666);
        repeat (3) step();

        // Heavy contention with backpressure
        repeat (300) begin offer(90); step(); end
        // Sparse traffic
        repeat (300) begin offer(20); step(); end
        // Reset with results buffered
        repeat (20) begin offer(95); step(); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (200) begin offer(60); step(); end

        // Drain
        repeat (12) step();
        left = 0;
        for (int i = 0; i < NS; i++) left += mq[i].size();
        check_val("drained", 64'(left), 64'd0);
        check_val("valid_idle", 64'(src_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
